adder64_arbiter: RTL and testbench

- Time-shares one combinational 64-bit carry-lookahead adder among NUM_REQ requesters in the calculations datapath.
- Requesters issue add or subtract operations through a request/grant handshake. A round-robin arbiter picks one requester, and the block registers its operands and drives them into the shared adder.
- The block captures the sum and overflow, then returns them to the winning requester with a one-cycle one-hot valid pulse.

---
 rtl/adder64_arbiter.sv | 153 +++++++++++++++
 tb/tb_adder64_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder64_arbiter.sv
// Round-robin front end that time-shares one external 64-bit adder among NUM_REQ requesters.
// Each granted op occupies the block for three cycles: grant/latch, execute, deliver.
module adder64_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ-1:0]      sub,
    input  logic [64*NUM_REQ-1:0]   a_in,
    input  logic [64*NUM_REQ-1:0]   b_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic                    busy,
    output logic [63:0]             add_a,
    output logic [63:0]             add_b,
    output logic                    add_cin,
    input  logic [63:0]             add_s,
    input  logic                    add_ovf,
    output logic [63:0]             res,
    output logic                    res_ovf,
    output logic [NUM_REQ-1:0]      res_valid
);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [63:0]        add_a_q, add_a_d;
    logic [63:0]        add_b_q, add_b_d;
    logic               add_cin_q, add_cin_d;
    logic [63:0]        res_q, res_d;
    logic               res_ovf_q, res_ovf_d;

    logic [PTR_W-1:0]   cand;
    logic [PTR_W-1:0]   win;
    logic               found;
    logic [63:0]        a_sel;
    logic [63:0]        b_sel;
    logic               s_sel;

    // Round-robin search starting one past the last winner, wrapping at NUM_REQ.
    always_comb begin
        cand  = ptr_q;
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cand == PTR_W'(NUM_REQ - 1)) begin
                cand = '0;
            end else begin
                cand = cand + PTR_W'(1);
            end
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        s_sel = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win == PTR_W'(k)) begin
                a_sel = a_in[64*k +: 64];
                b_sel = b_in[64*k +: 64];
                s_sel = sub[k];
            end
        end
    end

    // Next-state logic: latch operands on grant, capture the sum one cycle later.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_cin_d = add_cin_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    add_a_d   = a_sel;
                    // Subtraction is a + ~b + 1: invert B and use the carry-in as the +1.
                    add_b_d   = s_sel ? ~b_sel : b_sel;
                    add_cin_d = s_sel;
                    owner_d   = win;
                    ptr_d     = win;
                    state_d   = StExec;
                end
            end
            StExec: begin
                res_d     = add_s;
                res_ovf_d = add_ovf;
                state_d   = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset drops any in-flight op and points priority at requester 0.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            ptr_q     <= PTR_W'(NUM_REQ - 1);
            owner_q   <= '0;
            add_a_q   <= '0;
            add_b_q   <= '0;
            add_cin_q <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            add_a_q   <= add_a_d;
            add_b_q   <= add_b_d;
            add_cin_q <= add_cin_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    // Output decode: grant is combinational in IDLE, result pulse is decoded from DONE.
    always_comb begin
        gnt       = '0;
        res_valid = '0;
        if (state_q == StIdle && found && resetn) begin
            gnt[win] = 1'b1;
        end
        if (state_q == StDone) begin
            res_valid[owner_q] = 1'b1;
        end
    end

    assign busy    = (state_q != StIdle);
    assign add_a   = add_a_q;
    assign add_b   = add_b_q;
    assign add_cin = add_cin_q;
    assign res     = res_q;
    assign res_ovf = res_ovf_q;

endmodule

// File: tb/tb_adder64_arbiter.sv
// Bench for adder64_arbiter: models the shared adder and scoreboards every result.
module tb_adder64_arbiter;

    localparam int NUM_REQ = 4;
    localparam int PTR_W   = 2;

    logic                  clock;
    logic                  resetn;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    sub;
    logic [64*NUM_REQ-1:0] a_in;
    logic [64*NUM_REQ-1:0] b_in;
    logic [NUM_REQ-1:0]    gnt;
    logic                  busy;
    logic [63:0]           add_a;
    logic [63:0]           add_b;
    logic                  add_cin;
    logic [63:0]           add_s;
    logic                  add_ovf;
    logic [63:0]           res;
    logic                  res_ovf;
    logic [NUM_REQ-1:0]    res_valid;

    typedef struct {
        int          idx;
        logic [63:0] r;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    adder64_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req),
        .sub       (sub),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .busy      (busy),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_ovf   (add_ovf),
        .res       (res),
        .res_ovf   (res_ovf),
        .res_valid (res_valid)
    );

    // Shared combinational adder living outside the block.
    assign add_s   = add_a + add_b + {63'b0, add_cin};
    assign add_ovf = (add_a[63] == add_b[63]) && (add_s[63] != add_a[63]);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [NUM_REQ-1:0] oh(input int k);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Reference arithmetic written directly as a+b / a-b with sign-based overflow.
    function automatic exp_t model(input int k, input logic [63:0] a, input logic [63:0] b,
                                   input logic s);
        exp_t e;
        e.idx = k;
        if (s) begin
            e.r   = a - b;
            e.ovf = (a[63] != b[63]) && (e.r[63] != a[63]);
        end else begin
            e.r   = a + b;
            e.ovf = (a[63] == b[63]) && (e.r[63] != a[63]);
        end
        return e;
    endfunction

    task automatic set_ops(input int k, input logic [63:0] a, input logic [63:0] b,
                           input logic s);
        a_in[64*k +: 64] = a;
        b_in[64*k +: 64] = b;
        sub[k]           = s;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        req    = '0;
        sub    = '0;
        a_in   = '0;
        b_in   = '0;
        resetn = 1'b0;
        @(negedge clock);
        n_checks++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset gnt: got %b want 0", gnt); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", busy); end
        n_checks++; if (res_valid !== 4'b0) begin n_fail++; $display("FAIL reset res_valid: got %b want 0", res_valid); end
        n_checks++; if (res !== 64'd0) begin n_fail++; $display("FAIL reset res: got %h want 0", res); end
        n_checks++; if (res_ovf !== 1'b0) begin n_fail++; $display("FAIL reset res_ovf: got %b want 0", res_ovf); end
        n_checks++; if (add_a !== 64'd0) begin n_fail++; $display("FAIL reset add_a: got %h want 0", add_a); end
        n_checks++; if (add_b !== 64'd0) begin n_fail++; $display("FAIL reset add_b: got %h want 0", add_b); end
        n_checks++; if (add_cin !== 1'b0) begin n_fail++; $display("FAIL reset add_cin: got %b want 0", add_cin); end
        @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_single_op(input string name, input int k, input logic [63:0] a,
                                  input logic [63:0] b, input logic s);
        exp_t e;
        @(posedge clock);
        #1;
        set_ops(k, a, b, s);
        req = oh(k);
        @(negedge clock);
        n_checks++;
        if (gnt !== oh(k)) begin n_fail++; $display("FAIL %s gnt: got %b want %b", name, gnt, oh(k)); end
        sb.push_back(model(k, a_in[64*k +: 64], b_in[64*k +: 64], sub[k]));
        @(posedge clock);
        #1;
        req = '0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b1 || gnt !== 4'b0 || res_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL %s exec: got busy=%b gnt=%b rv=%b want 1/0000/0000", name, busy, gnt, res_valid);
        end
        @(negedge clock);
        n_checks++;
        if (res_valid !== oh(k)) begin n_fail++; $display("FAIL %s res_valid: got %b want %b", name, res_valid, oh(k)); end
        e = sb.pop_front();
        n_checks++;
        if (res !== e.r || res_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL %s result: got %h ovf=%b want %h ovf=%b", name, res, res_ovf, e.r, e.ovf);
        end
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 4'b0 || res !== e.r) begin
            n_fail++;
            $display("FAIL %s after: got busy=%b rv=%b res=%h want 0/0000/%h", name, busy, res_valid, res, e.r);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   grants   = 0;
        int   results  = 0;
        int   want     = 0;
        int   last_cyc = -1;
        int   cyc      = 0;
        int   refresh  = -1;
        do_reset();
        for (int k = 0; k < NUM_REQ; k++) begin
            set_ops(k, {$urandom, $urandom}, {$urandom, $urandom}, k[0]);
        end
        req = 4'hF;
        while ((grants < 12 || results < 12) && cyc < 80) begin
            if (cyc > 0) begin
                @(posedge clock);
                #1;
                if (refresh >= 0) begin
                    set_ops(refresh, {$urandom, $urandom}, {$urandom, $urandom},
                            1'($urandom_range(0, 1)));
                    refresh = -1;
                end
                if (grants >= 12) req = '0;
            end
            @(negedge clock);
            cyc++;
            if (gnt !== 4'b0) begin
                n_checks++;
                if (gnt !== oh(want)) begin n_fail++; $display("FAIL rr grant %0d: got %b want %b", grants, gnt, oh(want)); end
                if (last_cyc >= 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 3) begin
                        n_fail++;
                        $display("FAIL rr spacing: got %0d cycles want 3", cyc - last_cyc);
                    end
                end
                sb.push_back(model(want, a_in[64*want +: 64], b_in[64*want +: 64], sub[want]));
                refresh  = want;
                last_cyc = cyc;
                want     = (want + 1) % NUM_REQ;
                grants++;
            end
            if (res_valid !== 4'b0) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL rr unexpected res_valid: got %b want 0000", res_valid);
                end else begin
                    e = sb.pop_front();
                    if (res_valid !== oh(e.idx) || res !== e.r || res_ovf !== e.ovf) begin
                        n_fail++;
                        $display("FAIL rr result: got rv=%b %h ovf=%b want rv=%b %h ovf=%b",
                                 res_valid, res, res_ovf, oh(e.idx), e.r, e.ovf);
                    end
                end
                results++;
            end
        end
        n_checks++;
        if (grants < 12 || results < 12) begin
            n_fail++;
            $display("FAIL rr timeout: got %0d grants %0d results want 12/12", grants, results);
        end
        req = '0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(posedge clock);
        #1;
        set_ops(2, 64'd100, 64'd23, 1'b0);
        req = oh(2);
        @(negedge clock);
        n_checks++;
        if (gnt !== oh(2)) begin n_fail++; $display("FAIL rstmid gnt: got %b want 0100", gnt); end
        @(posedge clock);
        #1;
        req    = '0;
        #1;
        resetn = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || res_valid !== 4'b0 || gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid async: got busy=%b rv=%b gnt=%b want 0/0000/0000", busy, res_valid, gnt);
        end
        @(negedge clock);
        n_checks++;
        if (res_valid !== 4'b0) begin n_fail++; $display("FAIL rstmid hold rv: got %b want 0000", res_valid); end
        @(posedge clock);
        #1;
        resetn = 1'b1;
        set_ops(0, 64'h1234, 64'h1111, 1'b1);
        set_ops(3, 64'd9, 64'd9, 1'b0);
        req = 4'b1101;
        @(negedge clock);
        n_checks++;
        if (gnt !== 4'b0001 || res_valid !== 4'b0) begin
            n_fail++;
            $display("FAIL rstmid regrant: got gnt=%b rv=%b want 0001/0000", gnt, res_valid);
        end
        sb.push_back(model(0, a_in[63:0], b_in[63:0], sub[0]));
        @(posedge clock);
        #1;
        req = '0;
        @(negedge clock);
        n_checks++;
        if (res_valid !== 4'b0) begin n_fail++; $display("FAIL rstmid stale: got %b want 0000", res_valid); end
        @(negedge clock);
        e = sb.pop_front();
        n_checks++;
        if (res_valid !== 4'b0001 || res !== e.r || res_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL rstmid result: got rv=%b %h ovf=%b want 0001 %h ovf=%b",
                     res_valid, res, res_ovf, e.r, e.ovf);
        end
        @(negedge clock);
    endtask

    task automatic test_ignore_busy();
        exp_t e;
        @(posedge clock);
        #1;
        set_ops(3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0);
        set_ops(1, 64'd1, 64'd1, 1'b0);
        req = oh(3);
        @(negedge clock);
        n_checks++;
        if (gnt !== 4'b1000) begin n_fail++; $display("FAIL busyreq gnt3: got %b want 1000", gnt); end
        sb.push_back(model(3, a_in[64*3 +: 64], b_in[64*3 +: 64], sub[3]));
        @(posedge clock);
        #1;
        req = 4'b0010;
        @(negedge clock);
        n_checks++;
        if (gnt !== 4'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busyreq exec: got gnt=%b busy=%b want 0000/1", gnt, busy);
        end
        @(posedge clock);
        #1;
        req = '0;
        @(negedge clock);
        e = sb.pop_front();
        n_checks++;
        if (gnt !== 4'b0 || res_valid !== 4'b1000 || res !== e.r || res_ovf !== e.ovf) begin
            n_fail++;
            $display("FAIL busyreq done: got gnt=%b rv=%b %h ovf=%b want 0000 1000 %h ovf=%b",
                     gnt, res_valid, res, res_ovf, e.r, e.ovf);
        end
        repeat (2) begin
            @(negedge clock);
            n_checks++;
            if (gnt !== 4'b0 || busy !== 1'b0 || res_valid !== 4'b0) begin
                n_fail++;
                $display("FAIL busyreq idle: got gnt=%b busy=%b rv=%b want 0000/0/0000", gnt, busy, res_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_op("add_5_7", 0, 64'd5, 64'd7, 1'b0);
        test_single_op("sub_3_10", 2, 64'd3, 64'd10, 1'b1);
        test_single_op("add_ovf", 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        test_single_op("sub_ovf", 3, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        test_round_robin();
        test_reset_mid();
        test_ignore_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
